fetch_buffer: RTL and testbench

- 2-wide in-order instruction queue between the fetch stage and dispatch.
- Absorbs fetch bursts and dispatch back-pressure, and drives the fetch stall (stall_dp) back upstream.
- Flushes completely on squash so that dispatch never sees wrong-path instructions.

---
 rtl/fetch_buffer_pkg.sv | 32 +++
 rtl/fetch_buffer_sat_counter.sv | 24 ++
 rtl/fetch_buffer.sv | 120 ++++++++++++
 tb/tb_fetch_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/dispatch definitions: packet type, NOP and
// fetch-buffer sizing constants used by fetch_buffer and dispatch.
package fetch_buffer_pkg;

  localparam int XLEN = 32;
  localparam int FB_DEPTH = 8;
  localparam int FB_PTR_W = $clog2(FB_DEPTH) + 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } IF_DP_PACKET;

  localparam IF_DP_PACKET IF_DP_BUBBLE = '{
    valid: 1'b0,
    inst:  NOP,
    PC:    '0,
    NPC:   '0
  };

  function automatic logic [1:0] lanes_valid(
    input logic v0,
    input logic v1
  );
    return {1'b0, v0} + {1'b0, v1};
  endfunction

endpackage

// File: rtl/fetch_buffer_sat_counter.sv
// Saturating event counter for the fetch-buffer perf
// outputs (only used with FETCH_BUFFER_PERF_EN).
module fetch_buffer_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_buffer.sv
// 2-wide in-order fetch->dispatch queue with squash flush.
// Optional perf counters under FETCH_BUFFER_PERF_EN.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash_valid,
  input  IF_DP_PACKET [1:0]      if_packet,
  input  logic [1:0]             dp_take,
  output IF_DP_PACKET [1:0]      dp_packet,
  output logic [1:0]             dp_count,
  output logic                   stall_dp,
  output logic [$clog2(DEPTH):0] free_slots
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_squash_flushes,
  output logic [31:0]            perf_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count;

  IF_DP_PACKET mem_q [DEPTH];

  logic [AW-1:0] h0, h1, t0, t1;
  logic [1:0]    n_enq, n_deq;
  logic          v0, v1, enq_en;

  always_comb begin
    count      = tail_q - head_q;
    free_slots = PW'(DEPTH) - count;
    // Registered state only: same-cycle dequeues are not credited.
    stall_dp   = free_slots < PW'(2);

    v0     = if_packet[0].valid;
    v1     = if_packet[1].valid;
    n_enq  = lanes_valid(v0, v1);
    enq_en = !stall_dp && !squash_valid;

    dp_count = (count >= PW'(2)) ? 2'd2 : count[1:0];
    n_deq    = (dp_take > dp_count) ? dp_count : dp_take;

    h0 = head_q[AW-1:0];
    h1 = h0 + 1'b1;
    t0 = tail_q[AW-1:0];
    t1 = v0 ? t0 + 1'b1 : t0;

    dp_packet[0] = (count != '0) ? mem_q[h0] : IF_DP_BUBBLE;
    dp_packet[1] = (count >= PW'(2)) ? mem_q[h1] : IF_DP_BUBBLE;

    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      squash_valid: begin
        head_d = '0;
        tail_d = '0;
      end
      default: begin
        head_d = head_q + PW'(n_deq);
        tail_d = enq_en ? tail_q + PW'(n_enq) : tail_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_en) begin
      if (v0) mem_q[t0] <= if_packet[0];
      if (v1) mem_q[t1] <= if_packet[1];
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  fetch_buffer_sat_counter #(.W(32)) u_perf_stall (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (stall_dp),
    .cnt_o  (perf_stall_cycles)
  );

  fetch_buffer_sat_counter #(.W(32)) u_perf_squash (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (squash_valid && (count != '0)),
    .cnt_o  (perf_squash_flushes)
  );

  fetch_buffer_sat_counter #(.W(32)) u_perf_empty (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (count == '0),
    .cnt_o  (perf_empty_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer.
// Expected values are hand-derived or from a small count/PC model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              squash;
  IF_DP_PACKET [1:0] if_packet;
  logic [1:0]        dp_take;
  IF_DP_PACKET [1:0] dp_packet;
  logic [1:0]        dp_count;
  logic              stall_dp;
  logic [3:0]        free_slots;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_squash_flushes;
  logic [31:0]       perf_empty_cycles;
`endif

  int n_chk;
  int n_fail;

  fetch_buffer dut (
    .clock        (clk),
    .reset        (rst_n),
    .squash_valid (squash),
    .if_packet    (if_packet),
    .dp_take      (dp_take),
    .dp_packet    (dp_packet),
    .dp_count     (dp_count),
    .stall_dp     (stall_dp),
    .free_slots   (free_slots)
`ifdef FETCH_BUFFER_PERF_EN
    ,
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_squash_flushes (perf_squash_flushes),
    .perf_empty_cycles   (perf_empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic IF_DP_PACKET mk(input logic [31:0] pc);
    IF_DP_PACKET p;
    p.valid = 1'b1;
    p.inst  = 32'h0000_0093;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  initial begin
    int exp_free [5];
    int exp_stall [5];
    int cnt;
    int deq;
    int acc;
    logic [31:0] hpc;
    logic [31:0] fpc;

    exp_free  = '{6, 4, 2, 0, 0};
    exp_stall = '{0, 0, 0, 1, 1};
    n_chk  = 0;
    n_fail = 0;
    rst_n     = 1'b0;
    squash    = 1'b0;
    if_packet = '0;
    dp_take   = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(dp_count), 0);
    chk("rst_stall", 32'(stall_dp), 0);
    chk("rst_free", 32'(free_slots), 8);
    chk("rst_v0", 32'(dp_packet[0].valid), 0);
    chk("rst_v1", 32'(dp_packet[1].valid), 0);
    chk("rst_nop", dp_packet[0].inst, NOP);

    rst_n = 1'b1;
    step();
    chk("idle_count", 32'(dp_count), 0);
    chk("idle_free", 32'(free_slots), 8);

    // Fill with no drain; fifth pair must be dropped
    for (int k = 0; k < 5; k++) begin
      if_packet = {mk(32'(8 * k + 4)), mk(32'(8 * k))};
      step();
      chk("fill_free", 32'(free_slots), 32'(exp_free[k]));
      chk("fill_stall", 32'(stall_dp), 32'(exp_stall[k]));
    end
    chk("full_count", 32'(dp_count), 2);
    chk("full_pc0", dp_packet[0].PC, 32'h0);
    chk("full_pc1", dp_packet[1].PC, 32'h4);

    // Steady 2-in/2-out across the wrap point
    cnt = 8;
    hpc = 32'h0;
    fpc = 32'h20;
    dp_take = 2'd2;
    for (int c = 0; c < 10; c++) begin
      if_packet = {mk(fpc + 32'd4), mk(fpc)};
      acc = ((8 - cnt) >= 2) ? 1 : 0;
      deq = (cnt >= 2) ? 2 : cnt;
      step();
      cnt = cnt + 2 * acc - deq;
      hpc = hpc + 32'(4 * deq);
      if (acc == 1) fpc = fpc + 32'd8;
      chk("wrap_pc0", dp_packet[0].PC, hpc);
      chk("wrap_pc1", dp_packet[1].PC, hpc + 32'd4);
      chk("wrap_free", 32'(free_slots), 32'(8 - cnt));
    end

    if_packet = '0;
    for (int i = 0; i < 8 && cnt > 0; i++) begin
      deq = (cnt >= 2) ? 2 : cnt;
      step();
      cnt = cnt - deq;
    end
    chk("drain_count", 32'(dp_count), 0);
    chk("drain_free", 32'(free_slots), 8);

    // Lane-1-only packet is compacted into the tail slot
    dp_take = 2'd0;
    if_packet[0] = '0;
    if_packet[1] = mk(32'h40);
    step();
    if_packet = '0;
    chk("cmp_count", 32'(dp_count), 1);
    chk("cmp_pc0", dp_packet[0].PC, 32'h40);
    chk("cmp_v1", 32'(dp_packet[1].valid), 0);
    chk("cmp_nop1", dp_packet[1].inst, NOP);
    chk("cmp_free", 32'(free_slots), 7);

    // dp_take beyond dp_count is clamped
    dp_take = 2'd2;
    step();
    dp_take = 2'd0;
    chk("clamp_count", 32'(dp_count), 0);
    chk("clamp_free", 32'(free_slots), 8);
    chk("clamp_stall", 32'(stall_dp), 0);
    if_packet = {mk(32'h54), mk(32'h50)};
    step();
    if_packet = '0;
    chk("clamp_pc0", dp_packet[0].PC, 32'h50);
    chk("clamp_pc1", dp_packet[1].PC, 32'h54);

    // Squash while full with simultaneous dequeue and enqueue
    for (int k = 0; k < 3; k++) begin
      if_packet = {mk(32'(32'h104 + 8 * k)), mk(32'(32'h100 + 8 * k))};
      step();
    end
    chk("sq_full_stall", 32'(stall_dp), 1);
    chk("sq_full_free", 32'(free_slots), 0);
    squash = 1'b1;
    dp_take = 2'd2;
    if_packet = {mk(32'h204), mk(32'h200)};
    #1;
    chk("sq_pre_count", 32'(dp_count), 2);
    chk("sq_pre_pc0", dp_packet[0].PC, 32'h50);
    step();
    squash = 1'b0;
    dp_take = 2'd0;
    if_packet = '0;
    chk("sq_count", 32'(dp_count), 0);
    chk("sq_free", 32'(free_slots), 8);
    chk("sq_v0", 32'(dp_packet[0].valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sq_idle_count", 32'(dp_count), 0);
    end
    if_packet = {mk(32'h304), mk(32'h300)};
    step();
    if_packet = '0;
    chk("post_sq_count", 32'(dp_count), 2);
    chk("post_sq_pc0", dp_packet[0].PC, 32'h300);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(dp_count), 0);
    chk("arst_free", 32'(free_slots), 8);
    chk("arst_v0", 32'(dp_packet[0].valid), 0);
    chk("arst_stall", 32'(stall_dp), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_rel_count", 32'(dp_count), 0);
    chk("arst_rel_free", 32'(free_slots), 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
